lsu: RTL and testbench

Load/store unit stage directly downstream of the execute stage. It takes the ALU result as the effective address and the second source operand as store data. It runs one memory transaction at a time over a valid/ready request and response bus, then hands aligned, extended load data (or completion of a store) to write-back. Single outstanding access, with a bounded-wait timeout that reports a bus error instead of hanging the core.

---
 rtl/lsu_if.sv | 48 ++++
 rtl/lsu.sv | 214 +++++++++++++++++++++
 tb/tb_lsu.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if.sv
// Bundle of the execute-side operation handshake, the memory request/response
// bus and the write-back completion signals of the load/store unit.
// The slave modport is the LSU's view. The master modport is the view of
// whatever surrounds it: the execute stage, memory and write-back.
interface lsu_if #(
  parameter int DATA_WIDTH = 32
);
  // execute-stage operation handshake
  logic                    i_sys_valid;
  logic                    o_sys_ready;
  logic [1:0]              i_lsu_op;
  logic [1:0]              i_lsu_size;
  logic                    i_lsu_unsigned;
  logic [DATA_WIDTH-1:0]   i_exu_res;
  logic [DATA_WIDTH-1:0]   i_idu_rs2_data;

  // memory request channel
  logic                    o_mem_req_valid;
  logic                    i_mem_req_ready;
  logic [DATA_WIDTH-1:0]   o_mem_addr;
  logic                    o_mem_wen;
  logic [DATA_WIDTH-1:0]   o_mem_wdata;
  logic [DATA_WIDTH/8-1:0] o_mem_wstrb;

  // memory response channel
  logic                    i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   i_mem_rsp_data;

  // write-back completion
  logic                    o_lsu_valid;
  logic [DATA_WIDTH-1:0]   o_lsu_rdata;
  logic                    o_lsu_err;

  modport slave (
    input  i_sys_valid, i_lsu_op, i_lsu_size, i_lsu_unsigned, i_exu_res,
           i_idu_rs2_data, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    output o_sys_ready, o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata,
           o_mem_wstrb, o_lsu_valid, o_lsu_rdata, o_lsu_err
  );

  modport master (
    output i_sys_valid, i_lsu_op, i_lsu_size, i_lsu_unsigned, i_exu_res,
           i_idu_rs2_data, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
    input  o_sys_ready, o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata,
           o_mem_wstrb, o_lsu_valid, o_lsu_rdata, o_lsu_err
  );
endinterface

// File: rtl/lsu.sv
// lsu.sv
// Load/store unit placed directly after the execute stage. It takes the ALU
// result as the effective address and rs2 as store data. It runs exactly one
// memory transaction at a time over the valid/ready request/response bus,
// then pulses completion to write-back with aligned, extended load data.
// REQ+RESP together are bounded by TIMEOUT_CYCLES. A stuck access finishes
// with an error instead of stalling the core forever.
//
// Optional macro: LSU_MISALIGN_TRAP_EN
//   defined   - a misaligned half/word access issues no memory request and
//               completes immediately with an error.
//   undefined - the misaligned low address bits are forced to zero and the
//               access proceeds normally (default build).
module lsu #(
  parameter int DATA_WIDTH     = 32,  // fixed at 32: four byte lanes
  parameter int TIMEOUT_CYCLES = 16   // must be at least 2
) (
  input logic  i_sys_clk,
  input logic  i_sys_rst,
  lsu_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The counter only needs to reach TIMEOUT_CYCLES-1. The cycle that would
  // take it to TIMEOUT_CYCLES is the cycle that aborts the access.
  localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]              state;
  logic [CNT_W-1:0]        tmo_cnt;

  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    wen_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    is_store;
  logic                    is_mem;
  logic [1:0]              size_eff;
  logic [DATA_WIDTH-1:0]   addr_aligned;
  logic [DATA_WIDTH-1:0]   wdata_next;
  logic [DATA_WIDTH/8-1:0] wstrb_next;
  logic                    trap_next;

  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Decode the incoming operation: normalise op/size, force natural
  // alignment on the address, and build the lane-replicated store data and
  // its byte strobes from the aligned address.
  always_comb begin
    is_store     = (bus.i_lsu_op == OP_STORE);
    is_mem       = (bus.i_lsu_op == OP_LOAD) || is_store;
    size_eff     = (bus.i_lsu_size == 2'b11) ? SZ_WORD : bus.i_lsu_size;
    addr_aligned = bus.i_exu_res;
    wdata_next   = '0;
    wstrb_next   = '0;
    case (size_eff)
      SZ_HALF: addr_aligned[0]   = 1'b0;
      SZ_WORD: addr_aligned[1:0] = 2'b00;
      default: ;
    endcase
    if (is_store) begin
      case (size_eff)
        SZ_BYTE: begin
          wdata_next = {4{bus.i_idu_rs2_data[7:0]}};
          wstrb_next = 4'b0001 << addr_aligned[1:0];
        end
        SZ_HALF: begin
          wdata_next = {2{bus.i_idu_rs2_data[15:0]}};
          wstrb_next = 4'b0011 << {addr_aligned[1], 1'b0};
        end
        default: begin
          wdata_next = bus.i_idu_rs2_data;
          wstrb_next = 4'b1111;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Flag memory operations whose address is not naturally aligned so that
  // they can complete with an error instead of touching memory.
  always_comb begin
    trap_next = 1'b0;
    if (is_mem) begin
      if (size_eff == SZ_HALF)
        trap_next = bus.i_exu_res[0];
      else if (size_eff == SZ_WORD)
        trap_next = (bus.i_exu_res[1:0] != 2'b00);
    end
  end
`else
  assign trap_next = 1'b0;
`endif

  // Select the addressed lane of the returned word and sign- or
  // zero-extend it. The address is already aligned at this point.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = bus.i_mem_rsp_data[7:0];
      2'd1:    lane_byte = bus.i_mem_rsp_data[15:8];
      2'd2:    lane_byte = bus.i_mem_rsp_data[23:16];
      default: lane_byte = bus.i_mem_rsp_data[31:24];
    endcase
    lane_half = addr_q[1] ? bus.i_mem_rsp_data[31:16] : bus.i_mem_rsp_data[15:0];
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                                     : {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, lane_half}
                                     : {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
      default: load_ext = bus.i_mem_rsp_data;
    endcase
  end

  // Transaction FSM. Request fields are captured once at accept so they
  // cannot move while memory stalls. The result and error are captured on
  // entry to DONE and held until the next completion. A response is only
  // looked at in RESP, so a response arriving after a timeout falls on the
  // floor.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wen_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_sys_valid) begin
            tmo_cnt <= '0;
            if (!is_mem) begin
              rdata_q <= '0;
              err_q   <= 1'b0;
              state   <= ST_DONE;
            end else if (trap_next) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= ST_DONE;
            end else begin
              addr_q     <= addr_aligned;
              wdata_q    <= wdata_next;
              wstrb_q    <= wstrb_next;
              wen_q      <= is_store;
              size_q     <= size_eff;
              unsigned_q <= bus.i_lsu_unsigned;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (tmo_cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (bus.i_mem_req_ready)
              state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.i_mem_rsp_valid) begin
            rdata_q <= wen_q ? '0 : load_ext;
            err_q   <= 1'b0;
            state   <= ST_DONE;
          end else if (tmo_cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_sys_ready     = (state == ST_IDLE);
  assign bus.o_mem_req_valid = (state == ST_REQ);
  assign bus.o_mem_addr      = addr_q;
  assign bus.o_mem_wen       = wen_q;
  assign bus.o_mem_wdata     = wdata_q;
  assign bus.o_mem_wstrb     = wstrb_q;
  assign bus.o_lsu_valid     = (state == ST_DONE);
  assign bus.o_lsu_rdata     = rdata_q;
  assign bus.o_lsu_err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu.sv
// Bench for the load/store unit. It runs a table of directed vectors,
// hand-written multi-cycle sequences (memory stalls, timeouts with a late
// response, reset mid-access) and randomized operations. Expected values
// come from a small reference model built on byte-lane arithmetic.
// Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic i_sys_clk = 1'b0;
  logic i_sys_rst = 1'b1;

  lsu_if bus ();

  lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .bus       (bus)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rsp;
    bit          e_req;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
  } vec_t;

  typedef struct {
    bit          req_seen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen;
    bit          stable;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        req_at_done;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  int n_checks = 0;
  int n_fails  = 0;
  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what the unit should do for one operation, worked out
  // from access size, byte offset and lane arithmetic.
  function automatic vec_t ref_model(input string name, input logic [1:0] op, input logic [1:0] size,
                                     input logic uns, input logic [31:0] addr, input logic [31:0] rs2,
                                     input logic [31:0] rsp, input int rw, input int sw);
    vec_t v;
    int nbytes;
    int offs;
    int lane;
    longint unsigned mask;
    longint unsigned val;
    logic [31:0] ea;
    v = '{name, op, size, uns, addr, rs2, rsp, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1};
    if (op != 2'b01 && op != 2'b10) return v;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    offs   = int'(addr % 32'(nbytes));
    if (TRAP_EN && offs != 0) begin
      v.e_err = 1'b1;
      return v;
    end
    ea     = addr - 32'(offs);
    lane   = int'(ea % 32'd4);
    mask   = (64'd1 << (8 * nbytes)) - 64'd1;
    v.e_req  = 1'b1;
    v.e_addr = ea;
    v.e_lat  = 3 + rw + sw;
    if (op == 2'b10) begin
      v.e_wen   = 1'b1;
      v.e_wstrb = 4'(((1 << nbytes) - 1) << lane);
      for (int i = 0; i < 4 / nbytes; i++)
        v.e_wdata = v.e_wdata | 32'((64'(rs2) & mask) << (8 * nbytes * i));
    end else begin
      val = (64'(rsp) >> (8 * lane)) & mask;
      if (!uns && val[8 * nbytes - 1]) val = val | ~mask;
      v.e_rdata = 32'(val);
    end
    return v;
  endfunction

  // Present one operation, act as the memory with the given stall counts
  // and record what the unit did, bounded by a cycle budget.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rsp,
                               input int req_wait, input int rsp_wait, input bit respond,
                               output obs_t o);
    int n;
    int stall;
    int cd;
    bit accepted;
    bit responded;
    o = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, -1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    n = 0;
    while (!bus.o_sys_ready && n < 20) begin
      @(negedge i_sys_clk);
      n++;
    end
    bus.i_sys_valid    = 1'b1;
    bus.i_lsu_op       = op;
    bus.i_lsu_size     = size;
    bus.i_lsu_unsigned = uns;
    bus.i_exu_res      = addr;
    bus.i_idu_rs2_data = rs2;
    @(negedge i_sys_clk);
    bus.i_sys_valid    = 1'b0;
    bus.i_lsu_op       = 2'($urandom_range(0, 3));
    bus.i_lsu_size     = 2'($urandom_range(0, 3));
    bus.i_lsu_unsigned = 1'($urandom_range(0, 1));
    bus.i_exu_res      = $urandom;
    bus.i_idu_rs2_data = $urandom;
    stall     = req_wait;
    cd        = rsp_wait;
    accepted  = 1'b0;
    responded = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.o_lsu_valid) begin
        o.lat         = k;
        o.rdata       = bus.o_lsu_rdata;
        o.err         = bus.o_lsu_err;
        o.req_at_done = bus.o_mem_req_valid;
        break;
      end
      bus.i_mem_rsp_valid = 1'b0;
      if (bus.o_mem_req_valid) begin
        if (!o.req_seen) begin
          o.req_seen = 1'b1;
          o.addr     = bus.o_mem_addr;
          o.wdata    = bus.o_mem_wdata;
          o.wstrb    = bus.o_mem_wstrb;
          o.wen      = bus.o_mem_wen;
        end else if (o.addr !== bus.o_mem_addr || o.wdata !== bus.o_mem_wdata ||
                     o.wstrb !== bus.o_mem_wstrb || o.wen !== bus.o_mem_wen) begin
          o.stable = 1'b0;
        end
        if (stall > 0) begin
          bus.i_mem_req_ready = 1'b0;
          stall--;
        end else begin
          bus.i_mem_req_ready = 1'b1;
          accepted = 1'b1;
        end
      end else begin
        bus.i_mem_req_ready = 1'b0;
        if (accepted && respond && !responded) begin
          if (cd == 0) begin
            bus.i_mem_rsp_valid = 1'b1;
            bus.i_mem_rsp_data  = rsp;
            responded = 1'b1;
          end else begin
            cd--;
          end
        end
      end
      @(negedge i_sys_clk);
    end
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_req_ready = 1'b0;
    @(negedge i_sys_clk);
    o.valid_after = bus.o_lsu_valid;
    o.ready_after = bus.o_sys_ready;
  endtask

  task automatic runAndCheck(input vec_t v, input int rw, input int sw);
    obs_t o;
    applyStimulus(v.op, v.size, v.uns, v.addr, v.rs2, v.rsp, rw, sw, 1'b1, o);
    checkOutput({v.name, " latency"}, 32'(o.lat), 32'(v.e_lat));
    checkOutput({v.name, " req_issued"}, 32'(o.req_seen), 32'(v.e_req));
    if (v.e_req) begin
      checkOutput({v.name, " mem_addr"}, o.addr, v.e_addr);
      checkOutput({v.name, " mem_wen"}, 32'(o.wen), 32'(v.e_wen));
      checkOutput({v.name, " mem_wstrb"}, 32'(o.wstrb), 32'(v.e_wstrb));
      checkOutput({v.name, " req_stable"}, 32'(o.stable), 32'd1);
      if (v.e_wen) checkOutput({v.name, " mem_wdata"}, o.wdata, v.e_wdata);
    end
    checkOutput({v.name, " rdata"}, o.rdata, v.e_rdata);
    checkOutput({v.name, " err"}, 32'(o.err), 32'(v.e_err));
    checkOutput({v.name, " pulse_one_cycle"}, 32'(o.valid_after), 32'd0);
    checkOutput({v.name, " ready_after_done"}, 32'(o.ready_after), 32'd1);
  endtask

  initial begin
    obs_t o;
    vec_t v;
    bit seen;

    bus.i_sys_valid     = 1'b0;
    bus.i_lsu_op        = 2'b00;
    bus.i_lsu_size      = 2'b00;
    bus.i_lsu_unsigned  = 1'b0;
    bus.i_exu_res       = 32'h0;
    bus.i_idu_rs2_data  = 32'h0;
    bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_data  = 32'h0;

    // directed vectors: name, op, size, uns, addr, rs2, rsp,
    // e_req, e_addr, e_wen, e_wstrb, e_wdata, e_rdata, e_err, e_lat
    vecs[0]  = '{"ld_w_100",   2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8899AABB,
                 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h8899AABB, 1'b0, 3};
    vecs[1]  = '{"ld_b_s_103", 2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000,
                 1'b1, 32'h103, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 3};
    vecs[2]  = '{"ld_b_u_103", 2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000,
                 1'b1, 32'h103, 1'b0, 4'h0, 32'h0, 32'h00000080, 1'b0, 3};
    vecs[3]  = '{"st_h_202",   2'b10, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'hDEADBEEF,
                 1'b1, 32'h202, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 3};
    vecs[4]  = '{"st_b_101",   2'b10, 2'b00, 1'b0, 32'h101, 32'h000000A5, 32'h0,
                 1'b1, 32'h101, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 3};
    vecs[5]  = '{"st_w_300",   2'b10, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,
                 1'b1, 32'h300, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3};
    vecs[6]  = '{"ld_h_s_002", 2'b01, 2'b01, 1'b0, 32'h002, 32'h0, 32'h80017FFF,
                 1'b1, 32'h002, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 3};
    vecs[7]  = '{"ld_h_u_000", 2'b01, 2'b01, 1'b1, 32'h000, 32'h0, 32'h12349876,
                 1'b1, 32'h000, 1'b0, 4'h0, 32'h0, 32'h00009876, 1'b0, 3};
    vecs[8]  = '{"op_none",    2'b00, 2'b10, 1'b0, 32'h440, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1};
    vecs[9]  = '{"op_11_none", 2'b11, 2'b10, 1'b0, 32'h444, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1};
    vecs[10] = '{"ld_sz11_w",  2'b01, 2'b11, 1'b0, 32'h010, 32'h0, 32'h01020304,
                 1'b1, 32'h010, 1'b0, 4'h0, 32'h0, 32'h01020304, 1'b0, 3};
    vecs[11] = '{"ld_w_102_mis", 2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344,
                 !TRAP_EN, 32'h100, 1'b0, 4'h0, 32'h0, TRAP_EN ? 32'h0 : 32'h11223344,
                 TRAP_EN, TRAP_EN ? 1 : 3};
    vecs[12] = '{"st_h_203_mis", 2'b10, 2'b01, 1'b0, 32'h203, 32'h00005566, 32'h0,
                 !TRAP_EN, 32'h202, 1'b1, 4'b1100, 32'h55665566, 32'h0,
                 TRAP_EN, TRAP_EN ? 1 : 3};

    // reset values while reset is held, then after release
    repeat (2) @(negedge i_sys_clk);
    checkOutput("rst sys_ready", 32'(bus.o_sys_ready), 32'd1);
    checkOutput("rst req_valid", 32'(bus.o_mem_req_valid), 32'd0);
    checkOutput("rst lsu_valid", 32'(bus.o_lsu_valid), 32'd0);
    checkOutput("rst mem_addr", bus.o_mem_addr, 32'h0);
    checkOutput("rst mem_wen", 32'(bus.o_mem_wen), 32'd0);
    checkOutput("rst mem_wdata", bus.o_mem_wdata, 32'h0);
    checkOutput("rst mem_wstrb", 32'(bus.o_mem_wstrb), 32'd0);
    checkOutput("rst rdata", bus.o_lsu_rdata, 32'h0);
    checkOutput("rst err", 32'(bus.o_lsu_err), 32'd0);
    i_sys_rst = 1'b0;
    @(negedge i_sys_clk);
    checkOutput("post_rst sys_ready", 32'(bus.o_sys_ready), 32'd1);

    // directed table with zero-wait memory
    for (int i = 0; i < 13; i++) runAndCheck(vecs[i], 0, 0);

    // request stalled three cycles: fields held, completion three cycles later
    v = ref_model("st_w_stall3", 2'b10, 2'b10, 1'b0, 32'h600, 32'hCAFEBABE, 32'h0, 3, 0);
    runAndCheck(v, 3, 0);
    // response stalled two cycles
    v = ref_model("ld_b_rspwait2", 2'b01, 2'b00, 1'b0, 32'h602, 32'h0, 32'h00F70000, 0, 2);
    runAndCheck(v, 0, 2);

    // timeout with no response, after a load that left rdata nonzero
    v = ref_model("ld_pre_tmo", 2'b01, 2'b10, 1'b0, 32'h700, 32'h0, 32'hFFFFFFFF, 0, 0);
    runAndCheck(v, 0, 0);
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h500, 32'h0, 32'h12345678, 0, 0, 1'b0, o);
    checkOutput("tmo_rsp latency", 32'(o.lat), 32'd17);
    checkOutput("tmo_rsp err", 32'(o.err), 32'd1);
    checkOutput("tmo_rsp rdata", o.rdata, 32'h0);
    checkOutput("tmo_rsp req_at_done", 32'(o.req_at_done), 32'd0);
    // late response after the abort must not produce a completion
    seen = 1'b0;
    bus.i_mem_rsp_data = 32'hA5A5A5A5;
    for (int k = 0; k < 3; k++) begin
      bus.i_mem_rsp_valid = 1'b1;
      @(negedge i_sys_clk);
      if (bus.o_lsu_valid || bus.o_mem_req_valid) seen = 1'b1;
    end
    bus.i_mem_rsp_valid = 1'b0;
    checkOutput("late_rsp ignored", 32'(seen), 32'd0);
    checkOutput("late_rsp sys_ready", 32'(bus.o_sys_ready), 32'd1);
    v = ref_model("ld_post_tmo", 2'b01, 2'b10, 1'b0, 32'h704, 32'h0, 32'h0BADF00D, 0, 0);
    runAndCheck(v, 0, 0);

    // timeout while the request is never accepted
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h540, 32'h11111111, 32'h0, 100, 0, 1'b1, o);
    checkOutput("tmo_req latency", 32'(o.lat), 32'd17);
    checkOutput("tmo_req err", 32'(o.err), 32'd1);
    checkOutput("tmo_req req_at_done", 32'(o.req_at_done), 32'd0);

    // reset in the middle of a stalled request abandons it
    bus.i_sys_valid    = 1'b1;
    bus.i_lsu_op       = 2'b01;
    bus.i_lsu_size     = 2'b10;
    bus.i_exu_res      = 32'h400;
    @(negedge i_sys_clk);
    bus.i_sys_valid    = 1'b0;
    checkOutput("midrst req_before", 32'(bus.o_mem_req_valid), 32'd1);
    #2 i_sys_rst = 1'b1;
    #1;
    checkOutput("midrst req_drop", 32'(bus.o_mem_req_valid), 32'd0);
    checkOutput("midrst sys_ready", 32'(bus.o_sys_ready), 32'd1);
    @(negedge i_sys_clk);
    i_sys_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_mem_req_ready = 1'b1;
      bus.i_mem_rsp_valid = 1'b1;
      @(negedge i_sys_clk);
      if (bus.o_lsu_valid) seen = 1'b1;
    end
    bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    checkOutput("midrst no_completion", 32'(seen), 32'd0);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r_op;
      logic [1:0] r_size;
      logic r_uns;
      logic [31:0] r_addr;
      logic [31:0] r_rs2;
      logic [31:0] r_rsp;
      int rw;
      int sw;
      r_op   = 2'($urandom_range(0, 3));
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      r_rs2  = $urandom;
      r_rsp  = $urandom;
      rw     = int'($urandom_range(0, 3));
      sw     = int'($urandom_range(0, 3));
      v = ref_model($sformatf("rand%0d", i), r_op, r_size, r_uns, r_addr, r_rs2, r_rsp, rw, sw);
      runAndCheck(v, rw, sw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
